// File: rtl/i2c_mon_pkg.sv
// Shared types for the multi-bus I2C monitor: event kinds, decoder states,
// the bus-independent record body and field offsets within a record.
package i2c_mon_pkg;

    typedef enum logic [1:0] {
        MON_START  = 2'b00,
        MON_RSTART = 2'b01,
        MON_BYTE   = 2'b10,
        MON_STOP   = 2'b11
    } mon_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BITS,
        ST_ACKB
    } dec_state_t;

    typedef struct packed {
        mon_kind_t  kind;
        logic       ack;
        logic [7:0] data;
    } mon_rec_t;

    localparam int REC_DATA_LSB = 0;
    localparam int REC_ACK_BIT  = 8;
    localparam int REC_KIND_LSB = 9;
    localparam int REC_BASE_W   = 11;
    localparam int REC_BID_LSB  = REC_BASE_W;

    function automatic int bid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_bus_decoder.sv
// One bus: scl/sda synchronizers, START/STOP/bit decoding and a one-entry
// holding register that the top-level arbiter drains. MON_TIMESTAMP_EN adds a timestamp.
module i2c_bus_decoder
    import i2c_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef MON_TIMESTAMP_EN
    , parameter int TS_W = 16
`endif
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            scl_i,
    input  logic            sda_i,
    input  logic            en_i,
`ifdef MON_TIMESTAMP_EN
    input  logic [TS_W-1:0] ts_i,
    output logic [TS_W-1:0] hold_ts_o,
`endif
    input  logic            grant_i,
    output logic            hold_full_o,
    output mon_rec_t        hold_rec_o,
    output logic            drop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_prev_reg;
    logic                   sda_prev_reg;
    dec_state_t             state_reg;
    logic [7:0]             shift_reg;
    logic [2:0]             bitcnt_reg;
    logic                   hold_full_reg;
    mon_rec_t               hold_rec_reg;
`ifdef MON_TIMESTAMP_EN
    logic [TS_W-1:0]        hold_ts_reg;
`endif

    logic     s_scl, s_sda;
    logic     scl_rise, start_cond, stop_cond;
    logic     ev_valid;
    mon_rec_t ev_rec;

    assign s_scl      = scl_sync_reg[SYNC_STAGES-1];
    assign s_sda      = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise   = s_scl & ~scl_prev_reg;
    assign start_cond = s_scl & scl_prev_reg & sda_prev_reg & ~s_sda;
    assign stop_cond  = s_scl & scl_prev_reg & ~sda_prev_reg & s_sda;

    always_comb begin
        ev_valid = 1'b0;
        ev_rec   = '{kind: MON_START, ack: 1'b0, data: 8'h00};
        if (en_i) begin
            if (start_cond) begin
                ev_valid    = 1'b1;
                ev_rec.kind = (state_reg == ST_IDLE) ? MON_START : MON_RSTART;
            end else if (stop_cond) begin
                ev_valid    = 1'b1;
                ev_rec.kind = MON_STOP;
            end else if (state_reg == ST_ACKB && scl_rise) begin
                ev_valid    = 1'b1;
                ev_rec.kind = MON_BYTE;
                ev_rec.ack  = ~s_sda;
                ev_rec.data = shift_reg;
            end
        end
    end

    // A grant in the same cycle frees the slot, so the new event is not lost.
    assign drop_o = ev_valid & hold_full_reg & ~grant_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_reg  <= '1;
            sda_sync_reg  <= '1;
            scl_prev_reg  <= 1'b1;
            sda_prev_reg  <= 1'b1;
            state_reg     <= ST_IDLE;
            shift_reg     <= '0;
            bitcnt_reg    <= '0;
            hold_full_reg <= 1'b0;
            hold_rec_reg  <= '0;
`ifdef MON_TIMESTAMP_EN
            hold_ts_reg   <= '0;
`endif
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_i};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_i};
            scl_prev_reg <= s_scl;
            sda_prev_reg <= s_sda;
            if (!en_i) begin
                state_reg     <= ST_IDLE;
                shift_reg     <= '0;
                bitcnt_reg    <= '0;
                hold_full_reg <= 1'b0;
                hold_rec_reg  <= '0;
`ifdef MON_TIMESTAMP_EN
                hold_ts_reg   <= '0;
`endif
            end else begin
                if (start_cond) begin
                    state_reg  <= ST_BITS;
                    shift_reg  <= '0;
                    bitcnt_reg <= '0;
                end else if (stop_cond) begin
                    state_reg  <= ST_IDLE;
                    shift_reg  <= '0;
                    bitcnt_reg <= '0;
                end else if (scl_rise) begin
                    case (state_reg)
                        ST_BITS: begin
                            shift_reg <= {shift_reg[6:0], s_sda};
                            if (bitcnt_reg == 3'd7) begin
                                state_reg  <= ST_ACKB;
                                bitcnt_reg <= '0;
                            end else begin
                                bitcnt_reg <= bitcnt_reg + 3'd1;
                            end
                        end
                        ST_ACKB: begin
                            state_reg  <= ST_BITS;
                            bitcnt_reg <= '0;
                        end
                        default: ;
                    endcase
                end

                if (ev_valid && (!hold_full_reg || grant_i)) begin
                    hold_full_reg <= 1'b1;
                    hold_rec_reg  <= ev_rec;
`ifdef MON_TIMESTAMP_EN
                    hold_ts_reg   <= ts_i;
`endif
                end else if (grant_i) begin
                    hold_full_reg <= 1'b0;
                end
            end
        end
    end

    assign hold_full_o = hold_full_reg;
    assign hold_rec_o  = hold_rec_reg;
`ifdef MON_TIMESTAMP_EN
    assign hold_ts_o   = hold_ts_reg;
`endif

endmodule

// File: rtl/i2c_multibus_monitor.sv
// Passive monitor for NUM_BUSES I2C buses: per-bus decoders, round-robin merge
// into a FWFT record FIFO. MON_TIMESTAMP_EN prepends a TS_W-bit cycle timestamp.
module i2c_multibus_monitor
    import i2c_mon_pkg::*;
#(
    parameter int  NUM_BUSES   = 16,
    parameter int  SYNC_STAGES = 2,
    parameter int  FIFO_DEPTH  = 16,
    parameter int  TS_W        = 16,
    localparam int BID_W       = bid_width(NUM_BUSES),
`ifdef MON_TIMESTAMP_EN
    localparam int REC_W       = BID_W + REC_BASE_W + TS_W,
`else
    localparam int REC_W       = BID_W + REC_BASE_W,
`endif
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_BUSES-1:0] scl_i,
    input  logic [NUM_BUSES-1:0] sda_i,
    input  logic [NUM_BUSES-1:0] bus_en_i,
    output logic                 rec_valid_o,
    input  logic                 rec_ready_i,
    output logic [REC_W-1:0]     rec_data_o,
    output logic [LVL_W-1:0]     level_o,
    output logic                 ovf_o,
    input  logic                 ovf_clr_i
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NUM_BUSES-1:0] hold_full;
    logic [NUM_BUSES-1:0] drop;
    logic [NUM_BUSES-1:0] grant;
    mon_rec_t             hold_rec [NUM_BUSES];
`ifdef MON_TIMESTAMP_EN
    logic [TS_W-1:0]      hold_ts [NUM_BUSES];
    logic [TS_W-1:0]      ts_cnt_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ts_cnt_reg <= '0;
        else         ts_cnt_reg <= ts_cnt_reg + 1'b1;
    end
`endif

    for (genvar gi = 0; gi < NUM_BUSES; gi++) begin : g_bus
        i2c_bus_decoder #(
            .SYNC_STAGES (SYNC_STAGES)
`ifdef MON_TIMESTAMP_EN
            , .TS_W      (TS_W)
`endif
        ) u_dec (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .scl_i       (scl_i[gi]),
            .sda_i       (sda_i[gi]),
            .en_i        (bus_en_i[gi]),
`ifdef MON_TIMESTAMP_EN
            .ts_i        (ts_cnt_reg),
            .hold_ts_o   (hold_ts[gi]),
`endif
            .grant_i     (grant[gi]),
            .hold_full_o (hold_full[gi]),
            .hold_rec_o  (hold_rec[gi]),
            .drop_o      (drop[gi])
        );
    end

    logic [BID_W-1:0] rr_ptr_reg;
    logic [BID_W-1:0] grant_idx;
    logic             grant_valid;
    logic             push, pop, fifo_full;
    logic [REC_W-1:0] wr_rec;
    logic [REC_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0] count_reg;
    logic             ovf_reg;

    // Scan from the pointer upward; iterating downward lets the nearest request win.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_BUSES - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_BUSES) idx = idx - NUM_BUSES;
            if (hold_full[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = BID_W'(idx);
            end
        end
    end

    assign rec_valid_o = (count_reg != '0);
    assign fifo_full   = (count_reg == LVL_W'(FIFO_DEPTH));
    assign pop         = rec_valid_o & rec_ready_i;
    assign push        = grant_valid & (~fifo_full | pop);

    for (genvar gi = 0; gi < NUM_BUSES; gi++) begin : g_grant
        assign grant[gi] = push && (grant_idx == BID_W'(gi));
    end

    always_comb begin
        wr_rec = '0;
        wr_rec[REC_BASE_W-1:0]       = hold_rec[grant_idx];
        wr_rec[REC_BID_LSB +: BID_W] = grant_idx;
`ifdef MON_TIMESTAMP_EN
        wr_rec[REC_BID_LSB + BID_W +: TS_W] = hold_ts[grant_idx];
`endif
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_reg] <= wr_rec;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (int'(grant_idx) == NUM_BUSES - 1) rr_ptr_reg <= '0;
                else                                  rr_ptr_reg <= grant_idx + 1'b1;
            end
            if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: ;
            endcase
            if (|drop)          ovf_reg <= 1'b1;
            else if (ovf_clr_i) ovf_reg <= 1'b0;
        end
    end

    // Gated so the output reads zero whenever nothing is queued.
    assign rec_data_o = rec_valid_o ? fifo_mem[rd_ptr_reg] : '0;
    assign level_o    = count_reg;
    assign ovf_o      = ovf_reg;

endmodule

// File: tb/tb_i2c_multibus_monitor.sv
// Scoreboard bench for i2c_multibus_monitor: bit-banged I2C on selected buses,
// expected records queued as stimulus is driven and checked as they are accepted.
module tb_i2c_multibus_monitor;

    localparam int NB     = 16;
    localparam int FD     = 16;
    localparam int BASE_W = 4 + 11;
`ifdef MON_TIMESTAMP_EN
    localparam int REC_W  = BASE_W + 16;
`else
    localparam int REC_W  = BASE_W;
`endif
    localparam int HP     = 6;
    localparam int K_START = 0, K_RSTART = 1, K_BYTE = 2, K_STOP = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NB-1:0]     scl = '1;
    logic [NB-1:0]     sda = '1;
    logic [NB-1:0]     bus_en = '1;
    logic              rec_valid;
    logic              rec_ready = 1'b1;
    logic [REC_W-1:0]  rec_data;
    logic [4:0]        level;
    logic              ovf;
    logic              ovf_clr = 1'b0;

    logic [BASE_W-1:0] exp_q[$];
    logic [BASE_W-1:0] exp_v;
    int n_cmp = 0, n_fail = 0, n_acc = 0;
    int cyc = 0, last_acc = 0, prev_acc = 0;
    bit ts_check = 1'b0;

    i2c_multibus_monitor dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .scl_i       (scl),
        .sda_i       (sda),
        .bus_en_i    (bus_en),
        .rec_valid_o (rec_valid),
        .rec_ready_i (rec_ready),
        .rec_data_o  (rec_data),
        .level_o     (level),
        .ovf_o       (ovf),
        .ovf_clr_i   (ovf_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [BASE_W-1:0] mk(input int bid, input int kind,
                                             input logic ack, input logic [7:0] d);
        logic [BASE_W-1:0] r;
        r = {4'(bid), 2'(kind), ack, d};
        return r;
    endfunction

    // Accepted-record monitor: one line per record, compared against the queue head.
    always @(negedge clk) begin
        if (rst_n && rec_valid && rec_ready) begin
            n_acc++;
            prev_acc = last_acc;
            last_acc = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_record: got %h, required no record", rec_data[BASE_W-1:0]);
            end else begin
                exp_v = exp_q.pop_front();
                if (rec_data[BASE_W-1:0] !== exp_v) begin
                    n_fail++;
                    $display("FAIL record: got %h, required %h", rec_data[BASE_W-1:0], exp_v);
                end else begin
                    $display("record bus=%0d kind=%0d ack=%0b byte=%h", rec_data[14:11],
                             rec_data[10:9], rec_data[8], rec_data[7:0]);
                end
            end
`ifdef MON_TIMESTAMP_EN
            if (ts_check) begin
                ts_check = 1'b0;
                n_cmp++;
                if (rec_data[REC_W-1 -: 16] >= 16'd100) begin
                    n_fail++;
                    $display("FAIL first_ts: got %0d, required < 100", rec_data[REC_W-1 -: 16]);
                end
            end
`endif
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_sda(input logic [NB-1:0] m, input logic b);
        sda = b ? (sda | m) : (sda & ~m);
    endtask

    task automatic i2c_start(input logic [NB-1:0] m);
        sda = sda | m;  wait_clks(HP);
        scl = scl | m;  wait_clks(HP);
        sda = sda & ~m; wait_clks(HP);
        scl = scl & ~m; wait_clks(HP);
    endtask

    task automatic i2c_stop(input logic [NB-1:0] m);
        sda = sda & ~m; wait_clks(HP);
        scl = scl | m;  wait_clks(HP);
        sda = sda | m;  wait_clks(HP);
    endtask

    task automatic i2c_bit(input logic [NB-1:0] m, input logic b);
        set_sda(m, b);  wait_clks(HP);
        scl = scl | m;  wait_clks(HP);
        scl = scl & ~m; wait_clks(HP);
    endtask

    task automatic i2c_byte(input logic [NB-1:0] m, input logic [7:0] d, input logic ack_lvl);
        for (int i = 7; i >= 0; i--) i2c_bit(m, d[i]);
        i2c_bit(m, ack_lvl);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || rec_valid) && t < 500) begin
            @(posedge clk);
            t++;
        end
        wait_clks(20);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d records still outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        n_cmp++;
        if (level !== 5'd0) begin
            n_fail++;
            $display("FAIL %s_level: got %0d, required 0", name, level);
        end
    endtask

    task automatic test_reset();
        wait_clks(3);
        n_cmp++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", rec_valid); end
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d, required 0", level); end
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
        n_cmp++; if (rec_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", rec_data); end
        rst_n = 1'b1;
        wait_clks(10);
        n_cmp++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b, required 0", rec_valid); end
    endtask

    task automatic test_bus0_write();
        exp_q.push_back(mk(0, K_START, 0, 8'h00));
        exp_q.push_back(mk(0, K_BYTE, 1, 8'h44));
        exp_q.push_back(mk(0, K_BYTE, 1, 8'hA5));
        exp_q.push_back(mk(0, K_STOP, 0, 8'h00));
        i2c_start(16'h0001);
        i2c_byte(16'h0001, 8'h44, 1'b0);
        i2c_byte(16'h0001, 8'hA5, 1'b0);
        i2c_stop(16'h0001);
        drain("bus0_write");
    endtask

    task automatic test_bus3_nack();
        exp_q.push_back(mk(3, K_START, 0, 8'h00));
        exp_q.push_back(mk(3, K_BYTE, 0, 8'h45));
        exp_q.push_back(mk(3, K_RSTART, 0, 8'h00));
        exp_q.push_back(mk(3, K_STOP, 0, 8'h00));
        i2c_start(16'h0008);
        i2c_byte(16'h0008, 8'h45, 1'b1);
        i2c_start(16'h0008);
        i2c_stop(16'h0008);
        drain("bus3_nack");
    endtask

    task automatic check_back_to_back(input string name);
        n_cmp++;
        if (last_acc - prev_acc != 1) begin
            n_fail++;
            $display("FAIL %s_spacing: got %0d cycles, required 1", name, last_acc - prev_acc);
        end
    endtask

    task automatic test_back_to_back();
        // Pointer sits at 4 after the bus-3 test, so bus 1 is reached first.
        exp_q.push_back(mk(1, K_START, 0, 8'h00));
        exp_q.push_back(mk(2, K_START, 0, 8'h00));
        i2c_start(16'h0006);
        drain("pair1");
        check_back_to_back("pair1");
        exp_q.push_back(mk(1, K_STOP, 0, 8'h00));
        i2c_stop(16'h0002);
        drain("bus1_stop");
        // Last grant was bus 1, pointer at 2: bus 2 first.
        exp_q.push_back(mk(2, K_RSTART, 0, 8'h00));
        exp_q.push_back(mk(1, K_START, 0, 8'h00));
        i2c_start(16'h0006);
        drain("pair2");
        check_back_to_back("pair2");
        exp_q.push_back(mk(2, K_STOP, 0, 8'h00));
        exp_q.push_back(mk(1, K_STOP, 0, 8'h00));
        i2c_stop(16'h0006);
        drain("pair3");
    endtask

    task automatic test_partial_and_enable();
        exp_q.push_back(mk(0, K_START, 0, 8'h00));
        i2c_start(16'h0001);
        for (int i = 0; i < 5; i++) i2c_bit(16'h0001, i[0]);
        exp_q.push_back(mk(0, K_STOP, 0, 8'h00));
        i2c_stop(16'h0001);
        drain("partial_stop");

        exp_q.push_back(mk(0, K_START, 0, 8'h00));
        i2c_start(16'h0001);
        drain("en_start");
        for (int i = 0; i < 3; i++) i2c_bit(16'h0001, 1'b1);
        bus_en[0] = 1'b0;
        for (int i = 0; i < 3; i++) i2c_bit(16'h0001, 1'b0);
        bus_en[0] = 1'b1;
        for (int i = 0; i < 2; i++) i2c_bit(16'h0001, 1'b1);
        i2c_bit(16'h0001, 1'b0);
        wait_clks(10);
        n_cmp++;
        if (rec_valid !== 1'b0 || level !== 5'd0) begin
            n_fail++;
            $display("FAIL reenable_quiet: valid=%b level=%0d, required valid=0 level=0", rec_valid, level);
        end
        exp_q.push_back(mk(0, K_START, 0, 8'h00));
        exp_q.push_back(mk(0, K_BYTE, 1, 8'h3C));
        exp_q.push_back(mk(0, K_STOP, 0, 8'h00));
        i2c_start(16'h0001);
        i2c_byte(16'h0001, 8'h3C, 1'b0);
        i2c_stop(16'h0001);
        drain("reenable");
    endtask

    task automatic test_overflow();
        int acc0;
        rec_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk(0, K_START, 0, 8'h00));
            i2c_start(16'h0001);
            exp_q.push_back(mk(0, K_STOP, 0, 8'h00));
            i2c_stop(16'h0001);
        end
        wait_clks(10);
        n_cmp++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovf_level16: got %0d, required 16", level); end
        exp_q.push_back(mk(0, K_START, 0, 8'h00));
        i2c_start(16'h0001);
        wait_clks(10);
        n_cmp++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovf_level_sat: got %0d, required 16", level); end
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_held: got %b, required 0", ovf); end
        n_cmp++;
        if (rec_data[BASE_W-1:0] !== mk(0, K_START, 0, 8'h00)) begin
            n_fail++;
            $display("FAIL stall_head: got %h, required %h", rec_data[BASE_W-1:0], mk(0, K_START, 0, 8'h00));
        end
        i2c_stop(16'h0001);
        wait_clks(10);
        n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b, required 1", ovf); end
        i2c_start(16'h0001);
        i2c_stop(16'h0001);
        ovf_clr = 1'b1;
        wait_clks(1);
        ovf_clr = 1'b0;
        wait_clks(2);
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b, required 0", ovf); end
        n_cmp++;
        if (rec_data[BASE_W-1:0] !== mk(0, K_START, 0, 8'h00)) begin
            n_fail++;
            $display("FAIL stall_stable: got %h, required %h", rec_data[BASE_W-1:0], mk(0, K_START, 0, 8'h00));
        end
        acc0 = n_acc;
        rec_ready = 1'b1;
        drain("overflow");
        n_cmp++;
        if (n_acc - acc0 != 17) begin
            n_fail++;
            $display("FAIL ovf_drain_count: got %0d, required 17", n_acc - acc0);
        end
    endtask

    task automatic test_reset_midbyte();
        rec_ready = 1'b0;
        i2c_start(16'h0001);
        i2c_byte(16'h0001, 8'h12, 1'b0);
        i2c_start(16'h0001);
        for (int i = 0; i < 3; i++) i2c_bit(16'h0001, 1'b1);
        wait_clks(10);
        n_cmp++; if (level !== 5'd3) begin n_fail++; $display("FAIL pre_reset_level: got %0d, required 3", level); end
        rst_n = 1'b0;
        #2;
        n_cmp++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b, required 0", rec_valid); end
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL async_reset_level: got %0d, required 0", level); end
        scl = '1;
        sda = '1;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(5);
        rec_ready = 1'b1;
        ts_check = 1'b1;
        exp_q.push_back(mk(0, K_START, 0, 8'h00));
        exp_q.push_back(mk(0, K_BYTE, 1, 8'h5A));
        exp_q.push_back(mk(0, K_STOP, 0, 8'h00));
        i2c_start(16'h0001);
        i2c_byte(16'h0001, 8'h5A, 1'b0);
        i2c_stop(16'h0001);
        drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_bus0_write();
        test_bus3_nack();
        test_back_to_back();
        test_partial_and_enable();
        test_overflow();
        test_reset_midbyte();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_multibus_monitor.md
Name: i2c_multibus_monitor

Overview:
- Passive, synthesizable I2C bus monitor for up to NUM_BUSES buses. It targets the same scl/sda vector that the i2cmb multi-bus controller drives.
- Each enabled bus is decoded into START, RSTART, BYTE and STOP events.
- Events from all buses are merged round-robin into one record FIFO, which is drained over a valid/ready stream.
- Sits beside the controller in the i2cmb environment and replaces per-bus BFM monitoring with one in-fabric observer.

Parameters:
- NUM_BUSES, 16, number of monitored buses (1..16).
- SYNC_STAGES, 2, synchronizer flops on each scl/sda input (2..4).
- FIFO_DEPTH, 16, record FIFO depth; power of two, at least 2.
- BID_W, $clog2(NUM_BUSES) with a minimum of 1, bus-id field width (derived).
- TS_W, 16, timestamp width; used only with MON_TIMESTAMP_EN.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous, active-low reset.
- scl_i  in  NUM_BUSES  raw I2C clock lines, asynchronous.
- sda_i  in  NUM_BUSES  raw I2C data lines, asynchronous.
- bus_en_i  in  NUM_BUSES  per-bus monitor enable.
- rec_valid_o  out  1  a record is available.
- rec_ready_i  in  1  consumer accepts the record.
- rec_data_o  out  REC_W  record. Base REC_W = BID_W+11; with MON_TIMESTAMP_EN, REC_W = BID_W+11+TS_W.
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- ovf_o  out  1  sticky: an event was lost.
- ovf_clr_i  in  1  synchronous clear of ovf_o.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - All decoders go to IDLE and all synchronizers load 1.
  - FIFO is emptied; rec_valid_o=0, rec_data_o=0, level_o=0, ovf_o=0.
- Record layout, MSB to LSB: [ts][bus_id][kind(2)][ack(1)][byte(8)].
  - kind: 00 START, 01 RSTART, 10 BYTE, 11 STOP.
  - ack and byte are 0 for every kind except BYTE.
- Per-bus decoder, operating on synchronized s_scl/s_sda and their previous-cycle copies:
  - START condition: s_sda falls while s_scl is high, both in this cycle and the previous one. STOP condition: s_sda rises under the same scl condition.
  - States:
    - IDLE: START -> emit START, go to BITS with bitcnt=0.
    - BITS: on each s_scl rise, shift s_sda in MSB first and increment bitcnt. After the 8th bit go to ACKB.
    - ACKB: on the s_scl rise, ack = ~s_sda. Emit BYTE, go to BITS with bitcnt=0.
    - Any state except IDLE: START -> emit RSTART, go to BITS with bitcnt=0 (partial byte discarded). STOP -> emit STOP, go to IDLE (partial byte discarded, no BYTE emitted).
  - STOP seen in IDLE: emit STOP, stay in IDLE.
  - bus_en_i low: decoder is forced to IDLE and its holding register is cleared. Re-enabling mid-transfer waits for the next START.
- Holding register: one entry per bus, loaded in the cycle after detection (cycle N+1).
  - If the register is still full when a new event is detected, the new event is dropped and ovf_o is set.
- Arbiter: round-robin over buses with a full holding register; at most one FIFO write per cycle.
  - Grant is blocked while the FIFO is full; blocked holding registers keep their data.
  - The round-robin pointer advances only on a grant, to the granted index plus 1, wrapping at NUM_BUSES.
- FIFO (first-word-fall-through):
  - Write at N+1 into an empty FIFO gives rec_valid_o=1 at N+2.
  - Pop when rec_valid_o && rec_ready_i.
  - Simultaneous push and pop when full is allowed; level is unchanged.
  - rec_data_o is held stable while rec_valid_o=1 and rec_ready_i=0.
  - level_o counts 0..FIFO_DEPTH.
- ovf_clr_i and a new overflow in the same cycle: overflow wins, ovf_o=1.
- End-to-end latency from a raw pin edge to rec_valid_o, with an empty FIFO and no contention: SYNC_STAGES+3 cycles.

Optional Feature:
- Macro MON_TIMESTAMP_EN.
  - Defined: a free-running TS_W-bit cycle counter (reset 0, wraps modulo 2^TS_W) is captured into the holding register at the detection cycle N. It is carried in the top TS_W bits of rec_data_o.
  - Undefined: no counter; REC_W=BID_W+11; TS_W is ignored.

Decomposition:
- Package i2c_mon_pkg holds:
  - the mon_kind_t enum (START, RSTART, BYTE, STOP);
  - the decoder state enum (IDLE, BITS, ACKB);
  - the record struct;
  - localparam field offsets.
- Sub-module i2c_bus_decoder: synchronizer, edge detect, state machine and holding register. One instance per bus, built by a generate loop.
- The arbiter and FIFO stay in the top level.

Test Plan:
- Bus 0 enabled, write to address 0x22 with data 0xA5 and ACKs, then STOP. Expect records START; BYTE 0x44 ack=1; BYTE 0xA5 ack=1; STOP, all with bus_id=0, in order.
- Bus 3: START, address byte 0x45 with NACK (sda high on the 9th clock), RSTART, STOP. Expect START, BYTE 0x45 ack=0, RSTART, STOP.
- Buses 1 and 2 raise START in the same cycle with the FIFO empty. Expect two records, bus 1 then bus 2, on consecutive cycles. A following simultaneous pair with the pointer at 2 gives bus 2 then bus 1.
- rec_ready_i held at 0 while 20 events arrive on bus 0, FIFO_DEPTH=16:
  - level_o saturates at 16;
  - the 17th event waits in the holding register;
  - a further event sets ovf_o=1;
  - ovf_clr_i returns ovf_o to 0;
  - draining yields exactly 17 records.
- STOP after 5 data bits: STOP record only, no BYTE. Deasserting bus_en_i mid-byte, then re-asserting it: no records until the next START.
- rst_ni pulsed low mid-byte with 3 records queued: rec_valid_o=0 and level_o=0 immediately (asynchronously). A later transfer decodes correctly. With MON_TIMESTAMP_EN, the first timestamp after reset is under 100.
